// File: rtl/mat3_pkg.sv
// mat3_pkg: shared dimensions, slot offset helper and state type for the 3x3 matrix packer
package mat3_pkg;
    localparam int MAT3_DIM = 3;
    localparam int MAT3_ELEMS = 9;
    typedef enum logic {FILL, HOLD} state_t;
    function automatic int mat3_slot(input int k, input int w);
        return (MAT3_ELEMS - 1 - k) * w;
    endfunction
endpackage

// File: rtl/mat3_out_reg.sv
// mat3_out_reg: single-entry valid/ready holding register with a delivered-item counter
module mat3_out_reg #(
    parameter int W = 36,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             ready,
    output logic             valid,
    output logic [W-1:0]     data,
    output logic [CNT_W-1:0] count,
    output logic             drain
);
    assign drain = valid & ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else begin
            valid <= load | (valid & ~ready);
            if (load) data <= load_data;
            if (drain) count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mat3_packer.sv
// mat3_packer: packs nine streamed elements into a 3x3 matrix word; MAT3_PACK_COLMAJOR_EN selects column-major input order
module mat3_packer
    import mat3_pkg::*;
#(
    parameter int ELEM_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [ELEM_W-1:0]   in_data,
    input  logic                       in_last,
    output logic                       mat_valid,
    input  logic                       mat_ready,
    output logic [MAT3_ELEMS*ELEM_W-1:0] mat_data,
    output logic                       frame_err,
    output logic [CNT_W-1:0]           mat_count
);
    localparam int PW = MAT3_ELEMS * ELEM_W;
    localparam int OW = $clog2(PW);
    state_t state, state_n;
    logic [3:0] cnt, slot;
    logic [PW-1:0] asm_q, asm_w;
    logic [OW-1:0] off;
    logic acc, done, drain, load;
`ifdef MAT3_PACK_COLMAJOR_EN
    assign slot = 4'(MAT3_DIM) * (cnt % 4'(MAT3_DIM)) + cnt / 4'(MAT3_DIM);
`else
    assign slot = cnt;
`endif
    assign off  = OW'(mat3_slot(int'(slot), ELEM_W));
    assign acc  = in_valid & in_ready;
    assign done = acc & (cnt == 4'(MAT3_ELEMS - 1));
    // in HOLD no element is accepted, so asm_w is the completed word waiting for the output slot
    assign load = (done & (~mat_valid | drain)) | ((state == HOLD) & drain);
    always_comb begin
        asm_w = asm_q;
        if (acc) asm_w[off +: ELEM_W] = in_data;
        state_n = (state == HOLD) ? (drain ? FILL : HOLD) : ((done & mat_valid & ~drain) ? HOLD : FILL);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            asm_q     <= '0;
            in_ready  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == FILL);
            asm_q     <= asm_w;
            frame_err <= acc & (in_last ^ (cnt == 4'(MAT3_ELEMS - 1)));
            cnt       <= acc ? ((done | in_last) ? 4'd0 : cnt + 4'd1) : cnt;
        end
    end
    mat3_out_reg #(.W(PW), .CNT_W(CNT_W)) u_out (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_data(asm_w),
        .ready(mat_ready),
        .valid(mat_valid),
        .data(mat_data),
        .count(mat_count),
        .drain(drain)
    );
endmodule

// File: tb/tb_mat3_packer.sv
// tb_mat3_packer: directed self-checking bench for mat3_packer
module tb_mat3_packer;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, mat_ready = 1'b1;
    logic signed [3:0] in_data = '0;
    logic in_ready, mat_valid, frame_err;
    logic [35:0] mat_data;
    logic [7:0] mat_count;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    mat3_packer #(.ELEM_W(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .mat_valid(mat_valid),
        .mat_ready(mat_ready),
        .mat_data(mat_data),
        .frame_err(frame_err),
        .mat_count(mat_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] d, input logic l);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // streams matrix m in the input order the build expects
    task automatic send_mat(input logic [35:0] m, input logic last);
        for (int k = 0; k < 9; k++) begin
            int s;
`ifdef MAT3_PACK_COLMAJOR_EN
            s = 3 * (k % 3) + k / 3;
`else
            s = k;
`endif
            put(m[(8 - s) * 4 +: 4], last && (k == 8));
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mat_valid", mat_valid, 0);
        chk("rst_mat_data", mat_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_mat_count", mat_count, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        send_mat(36'h123456789, 1'b1);
        chk("f1_valid", mat_valid, 1);
        chk("f1_data", mat_data, 36'h123456789);
        chk("f1_count_pre", mat_count, 0);
        chk("f1_frame_err", frame_err, 0);
        tick();
        chk("f1_count", mat_count, 1);
        chk("f1_valid_drop", mat_valid, 0);

        send_mat(36'hFFFFFFFFF, 1'b1);
        chk("b2b_a_valid", mat_valid, 1);
        chk("b2b_a_data", mat_data, 36'hFFFFFFFFF);
        for (int k = 0; k < 8; k++) put(4'h2, 1'b0);
        chk("b2b_gap_valid", mat_valid, 0);
        chk("b2b_count_mid", mat_count, 2);
        put(4'h2, 1'b1);
        chk("b2b_b_valid", mat_valid, 1);
        chk("b2b_b_data", mat_data, 36'h222222222);
        chk("b2b_in_ready", in_ready, 1);
        tick();
        chk("b2b_count", mat_count, 3);

        mat_ready = 1'b0;
        send_mat(36'h111111111, 1'b1);
        chk("stall_a_valid", mat_valid, 1);
        chk("stall_a_data", mat_data, 36'h111111111);
        send_mat(36'h333333333, 1'b1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_data_stable", mat_data, 36'h111111111);
        chk("hold_valid", mat_valid, 1);
        tick();
        chk("hold_in_ready_2", in_ready, 0);
        chk("hold_data_stable_2", mat_data, 36'h111111111);
        mat_ready = 1'b1;
        tick();
        mat_ready = 1'b0;
        chk("release_valid", mat_valid, 1);
        chk("release_data", mat_data, 36'h333333333);
        chk("release_in_ready", in_ready, 1);
        chk("release_count", mat_count, 4);
        mat_ready = 1'b1;
        tick();
        chk("release_count_2", mat_count, 5);
        chk("release_valid_drop", mat_valid, 0);

        for (int k = 0; k < 4; k++) put(4'(k + 1), 1'b0);
        put(4'h5, 1'b1);
        chk("short_frame_err", frame_err, 1);
        chk("short_no_valid", mat_valid, 0);
        tick();
        chk("short_err_pulse_end", frame_err, 0);
        chk("short_still_no_valid", mat_valid, 0);
        send_mat(36'h123456789, 1'b1);
        chk("after_short_data", mat_data, 36'h123456789);
        chk("after_short_valid", mat_valid, 1);
        tick();
        chk("after_short_count", mat_count, 6);

        send_mat(36'h987654321, 1'b0);
        chk("nolast_frame_err", frame_err, 1);
        chk("nolast_valid", mat_valid, 1);
        chk("nolast_data", mat_data, 36'h987654321);
        tick();
        chk("nolast_err_end", frame_err, 0);
        chk("nolast_count", mat_count, 7);

        mat_ready = 1'b0;
        send_mat(36'h555555555, 1'b1);
        for (int k = 0; k < 6; k++) put(4'h7, 1'b0);
        chk("pre_rst_held", mat_valid, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", mat_valid, 0);
        chk("mid_rst_count", mat_count, 0);
        chk("mid_rst_data", mat_data, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst = 1'b0;
        mat_ready = 1'b1;
        tick();
        chk("after_rst_in_ready", in_ready, 1);
        send_mat(36'hA1B2C3D4E, 1'b1);
        chk("fresh_valid", mat_valid, 1);
        chk("fresh_data", mat_data, 36'hA1B2C3D4E);
        chk("fresh_frame_err", frame_err, 0);
        tick();
        chk("fresh_count", mat_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
